// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed driver for an N-digit common-anode seven-segment display.
//   A memory-mapped register writes the digit value, decimal points and
//   per-digit enables through a single-cycle load strobe. The block then
//   scans the digits at a programmable slot rate. A short all-anodes-off
//   window at the start of every slot suppresses ghosting. Leading zeros
//   can optionally be blanked.
//
// Ports
//   clk       system clock
//   n_rst     asynchronous active-low reset
//   load      latch strobe for value_in / dp_in / digit_en
//   value_in  4*NUM_DIGITS hex nibbles, nibble i drives digit i (digit 0 rightmost)
//   dp_in     per-digit decimal point request, active-high
//   digit_en  per-digit enable, active-high
//   blank_lz  leading-zero blanking mode, sampled live (not latched)
//   seg_n     {CA,CB,CC,CD,CE,CF,CG,DP}, active-low, registered
//   an_n      anode selects, active-low, at most one low, registered
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]           cnt_reg;
  logic [IW-1:0]           idx_reg;
  logic [4*NUM_DIGITS-1:0] val_reg;
  logic [NUM_DIGITS-1:0]   dp_reg;
  logic [NUM_DIGITS-1:0]   en_reg;

  logic                    cnt_wrap;
  logic                    idx_wrap;
  logic                    in_blank;
  logic                    lz_blank;
  logic                    lit;
  logic [3:0]              nibble;
  logic [6:0]              glyph;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [7:0]              seg_next;

  // Active-high {a,b,c,d,e,f,g} pattern for one hex digit.
  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    logic [6:0] g;
    g = 7'b0000000;
    case (h)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      4'hF: g = 7'b1000111;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  assign cnt_wrap = (cnt_reg == CW'(REFRESH_DIV - 1));
  assign idx_wrap = (idx_reg == IW'(NUM_DIGITS - 1));

  // Anti-ghosting window at the head of each slot; compiled away when zero.
  generate
    if (BLANK_CYCLES > 0) begin : gen_blank
      assign in_blank = (cnt_reg < CW'(BLANK_CYCLES));
    end else begin : gen_noblank
      assign in_blank = 1'b0;
    end
  endgenerate

  // upper_zero[i]: nibbles i..NUM_DIGITS-1 are all zero. Each bit is
  // computed directly from the shadow value (no ripple chain), so the
  // comparison stays flat.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : gen_lz
      assign upper_zero[gi] = ~|val_reg[4*NUM_DIGITS-1:4*gi];
    end
  endgenerate

  // Digit 0 is never blanked, so a value of zero still shows one '0'.
  assign lz_blank = blank_lz && (idx_reg != '0) && upper_zero[idx_reg];
  assign lit      = !in_blank && en_reg[idx_reg] && !lz_blank;

  assign nibble   = val_reg[{idx_reg, 2'b00} +: 4];
  assign glyph    = hex_glyph(nibble);
  assign seg_next = lit ? ~{glyph, dp_reg[idx_reg]} : 8'hFF;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : gen_an
      assign an_next[gi] = !(lit && (idx_reg == IW'(gi)));
    end
  endgenerate

  // Outputs are registered from the pre-edge scan state, which gives one
  // cycle of latency. Blanked slots still take their full time, so
  // brightness does not depend on content.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_reg <= '0;
      idx_reg <= '0;
      val_reg <= '0;
      dp_reg  <= '0;
      en_reg  <= '0;
      seg_n   <= 8'hFF;
      an_n    <= '1;
    end else begin
      if (load) begin
        val_reg <= value_in;
        dp_reg  <= dp_in;
        en_reg  <= digit_en;
      end
      if (cnt_wrap) begin
        cnt_reg <= '0;
        idx_reg <= idx_wrap ? '0 : idx_reg + 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      seg_n <= seg_next;
      an_n  <= an_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed testbench for seven_seg_scanner with NUM_DIGITS=4, REFRESH_DIV=4
// and BLANK_CYCLES=1. A table of vectors is applied from a fresh reset, and
// each vector is checked over a full frame. Hand-written sequences then cover
// reset, load latency, a load at a slot wrap, live blank_lz and asynchronous
// reset in mid-scan.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  digit_en = 4'h0;
  logic        blank_lz = 1'b0;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        lz;
    logic [3:0]  lit;   // digits expected to light
    logic [31:0] segs;  // expected seg_n per digit, digit i at [8i+:8]
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS(4),
    .REFRESH_DIV(4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .load(load),
    .value_in(value_in),
    .dp_in(dp_in),
    .digit_en(digit_en),
    .blank_lz(blank_lz),
    .seg_n(seg_n),
    .an_n(an_n)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [3:0] an_exp, input logic [7:0] seg_exp);
    total++;
    if (an_n !== an_exp || seg_n !== seg_exp) begin
      bad++;
      $display("FAIL %s: got an_n=%b seg_n=%h, want an_n=%b seg_n=%h", name, an_n, seg_n, an_exp, seg_exp);
    end else begin
      $display("ok   %s: an_n=%b seg_n=%h", name, an_n, seg_n);
    end
  endtask

  // Reset, then release with a load pending, so the load is captured on
  // edge 1. Edge 1 is always blanked (cnt=0), and edge 2 is digit 0's first
  // lit cycle.
  task automatic restart(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en, input logic lz);
    @(negedge clk);
    n_rst = 1'b0;
    load  = 1'b0;
    tick();
    tick();
    value_in = v;
    dp_in    = dp;
    digit_en = en;
    blank_lz = lz;
    load     = 1'b1;
    n_rst    = 1'b1;
    tick();
    load = 1'b0;
    check("edge1_blank", 4'b1111, 8'hFF);
  endtask

  initial begin
    //                value     dp       en       lz    lit      segs {d3,d2,d1,d0}
    vecs[0] = '{16'h12AF, 4'b0000, 4'b1111, 1'b0, 4'b1111, {8'h9F, 8'h25, 8'h11, 8'h71}};
    vecs[1] = '{16'h0005, 4'b0000, 4'b1111, 1'b1, 4'b0001, {8'hFF, 8'hFF, 8'hFF, 8'h49}};
    vecs[2] = '{16'h0005, 4'b0000, 4'b1111, 1'b0, 4'b1111, {8'h03, 8'h03, 8'h03, 8'h49}};
    vecs[3] = '{16'h0105, 4'b0000, 4'b1111, 1'b1, 4'b0111, {8'hFF, 8'h9F, 8'h03, 8'h49}};
    vecs[4] = '{16'h0000, 4'b0001, 4'b1011, 1'b0, 4'b1011, {8'h03, 8'hFF, 8'h03, 8'h02}};
    vecs[5] = '{16'h8C3B, 4'b1010, 4'b1111, 1'b1, 4'b1111, {8'h00, 8'h63, 8'h0C, 8'hC1}};
    vecs[6] = '{16'h0E6D, 4'b0000, 4'b1111, 1'b1, 4'b0111, {8'hFF, 8'h61, 8'h41, 8'h85}};
    vecs[7] = '{16'h4790, 4'b0000, 4'b1111, 1'b1, 4'b1111, {8'h99, 8'h1F, 8'h09, 8'h03}};

    // Reset held with load active: outputs stay dark and nothing is latched.
    n_rst    = 1'b0;
    load     = 1'b1;
    value_in = 16'hFFFF;
    digit_en = 4'hF;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("reset_hold%0d", i), 4'b1111, 8'hFF);
      tick();
    end
    restart(16'h0000, 4'h0, 4'hF, 1'b0);
    tick();
    check("reset_first_lit", 4'b1110, 8'h03);

    // Table vectors: one full frame (edges 2..17), including the wrap back to digit 0.
    for (int v = 0; v < 8; v++) begin
      restart(vecs[v].value, vecs[v].dp, vecs[v].en, vecs[v].lz);
      for (int k = 2; k <= 17; k++) begin
        int c;
        int d;
        logic [3:0] an_e;
        logic [7:0] seg_e;
        tick();
        c = (k - 1) % 4;
        d = ((k - 1) / 4) % 4;
        if (c == 0 || !vecs[v].lit[d]) begin
          an_e  = 4'b1111;
          seg_e = 8'hFF;
        end else begin
          an_e  = ~(4'b0001 << d);
          seg_e = vecs[v].segs[8*d +: 8];
        end
        check($sformatf("vec%0d_edge%0d", v, k), an_e, seg_e);
      end
    end

    // Load latency: new data shows one edge after the load edge.
    restart(16'h12AF, 4'h0, 4'hF, 1'b0);
    tick();
    check("lat_edge2", 4'b1110, 8'h71);
    value_in = 16'h12A5;
    load     = 1'b1;
    tick();
    load = 1'b0;
    check("lat_edge3_old", 4'b1110, 8'h71);
    // Load coinciding with the slot wrap at edge 4.
    value_in = 16'h1235;
    load     = 1'b1;
    tick();
    load = 1'b0;
    check("lat_edge4_new", 4'b1110, 8'h49);
    tick();
    check("wrap_edge5_blank", 4'b1111, 8'hFF);
    tick();
    check("wrap_edge6_d1", 4'b1101, 8'h0D);

    // blank_lz is sampled live, mid-slot.
    restart(16'h0005, 4'h0, 4'hF, 1'b1);
    for (int k = 2; k <= 6; k++) tick();
    check("lz_live_on", 4'b1111, 8'hFF);
    blank_lz = 1'b0;
    tick();
    check("lz_live_off", 4'b1101, 8'h03);

    // Asynchronous reset while digit 2 is lit.
    restart(16'h12AF, 4'h0, 4'hF, 1'b0);
    for (int k = 2; k <= 10; k++) tick();
    check("async_pre_d2", 4'b1011, 8'h25);
    #1 n_rst = 1'b0;
    #1 check("async_immediate", 4'b1111, 8'hFF);
    @(negedge clk);
    check("async_held", 4'b1111, 8'hFF);
    value_in = 16'h12AF;
    digit_en = 4'hF;
    load     = 1'b1;
    n_rst    = 1'b1;
    tick();
    load = 1'b0;
    check("async_rel_edge1", 4'b1111, 8'hFF);
    tick();
    check("async_rel_d0", 4'b1110, 8'h71);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
